// File: rtl/wb_stage.sv
// Writeback stage: accepts a retired instruction from execute, issues at most one
// register-file write per instruction, counts retirements and flags unsupported opcodes.
`timescale 1ns/1ps
module wb_stage #(
  parameter int BITSIZE = 32
) (
  input  logic               clk,
  input  logic               reset_i,
  input  logic               EX_WB_give_i,
  output logic               WB_EX_get_o,
  input  logic [31:0]        EX_WB_instruction_i,
  input  logic [BITSIZE-1:0] EX_WB_d_i,
  output logic               WB_RF_give_o,
  input  logic               RF_WB_get_i,
  output logic [4:0]         WB_RF_addr_o,
  output logic [BITSIZE-1:0] WB_RF_data_o,
  output logic               WB_illegal_o,
  output logic [63:0]        WB_retired_o
);

  typedef enum logic {GET_INSTR, WRITE_REG} state_e;

  localparam logic [6:0] OP_LUI         = 7'b0110111;
  localparam logic [6:0] OP_AUIPC       = 7'b0010111;
  localparam logic [6:0] OP_IMM_REG_ALU = 7'b0010011;
  localparam logic [6:0] OP_REG_REG_ALU = 7'b0110011;

  state_e               state_q, state_d;
  logic [4:0]           addr_q, addr_d;
  logic [BITSIZE-1:0]   data_q, data_d;
  logic                 illegal_q, illegal_d;
  logic [63:0]          retired_q;
  logic                 retire;

  logic [6:0] opcode;
  logic [4:0] rd;
  logic       is_writing_op;
  logic       unused_instr_bits;

  assign opcode            = EX_WB_instruction_i[6:0];
  assign rd                = EX_WB_instruction_i[11:7];
  assign unused_instr_bits = ^EX_WB_instruction_i[31:12];
  assign is_writing_op     = (opcode == OP_LUI) || (opcode == OP_AUIPC) ||
                             (opcode == OP_IMM_REG_ALU) || (opcode == OP_REG_REG_ALU);

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    illegal_d = 1'b0;
    retire    = 1'b0;
    case (state_q)
      GET_INSTR: begin
        if (EX_WB_give_i) begin
          addr_d = rd;
          data_d = EX_WB_d_i;
          if (is_writing_op && (rd != 5'd0)) begin
            state_d = WRITE_REG;
          end else begin
            retire    = 1'b1;
            illegal_d = !is_writing_op;
          end
        end
      end
      WRITE_REG: begin
        if (RF_WB_get_i) begin
          retire  = 1'b1;
          state_d = GET_INSTR;
        end
      end
      default: state_d = GET_INSTR;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= GET_INSTR;
      addr_q    <= '0;
      data_q    <= '0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      illegal_q <= illegal_d;
      if (retire) retired_q <= retired_q + 64'd1;
    end
  end

  // Accept is gated by reset so execute never sees a handshake that reset would discard.
  assign WB_EX_get_o  = (state_q == GET_INSTR) && !reset_i;
  assign WB_RF_give_o = (state_q == WRITE_REG);
  assign WB_RF_addr_o = addr_q;
  assign WB_RF_data_o = data_q;
  assign WB_illegal_o = illegal_q;
  assign WB_retired_o = retired_q;

endmodule
